fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR filter. One multiplier and one accumulator are
//   shared across all taps. Each accepted sample is written into a circular
//   delay line. The sample then takes TAPS multiply-accumulate cycles, and the
//   aligned result is held on the output until it is consumed.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     : sample input stream
//   out_valid/out_ready/out_data  : filtered output stream
//   coef_we/coef_addr/coef_data   : coefficient write port (IDLE only)
//   coef_err                      : one-cycle pulse when a coefficient write
//                                   arrives outside IDLE and is dropped
//   dbg_state                     : current FSM state (IDLE=0, MAC=1, OUT=2)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. The ready signals here depend only on the FSM state, so they
// never depend combinationally on the partner's valid.
module fir_mac_sequencer #(
  parameter int TAPS       = 8,
  parameter int X_WORD_LEN = 9,
  parameter int X_FRAC_LEN = 8,
  parameter int H_WORD_LEN = 9,
  parameter int H_FRAC_LEN = 8,
  parameter int Y_WORD_LEN = 9,
  parameter int Y_FRAC_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [X_WORD_LEN-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Y_WORD_LEN-1:0]    out_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [H_WORD_LEN-1:0]    coef_data,
  output logic                     coef_err,
  output logic [1:0]               dbg_state
);

  localparam int AW     = $clog2(TAPS);
  localparam int P_W    = X_WORD_LEN + H_WORD_LEN;
  localparam int P_FRAC = X_FRAC_LEN + H_FRAC_LEN;
  // Headroom of clog2(TAPS) bits lets TAPS full-scale products add up
  // without overflow.
  localparam int ACC_W  = P_W + AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, next_state;

  logic        [AW-1:0]         wr_ptr;
  logic        [AW-1:0]         tap_cnt;
  logic        [AW-1:0]         rd_idx;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_sum;
  logic signed [P_W-1:0]        prod;
  logic        [Y_WORD_LEN-1:0] y_aligned;
  logic                         accept;
  logic                         addr_ok;

  logic signed [X_WORD_LEN-1:0] xline [TAPS];
  logic signed [H_WORD_LEN-1:0] hcoef [TAPS];

  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign addr_ok   = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  // x[(n-k) mod TAPS]: the newest sample sits at wr_ptr. Subtracting in AW
  // bits gives the modulo wrap directly.
  assign rd_idx  = wr_ptr - tap_cnt;
  assign prod    = P_W'(xline[rd_idx]) * P_W'(hcoef[tap_cnt]);
  assign acc_sum = acc + ACC_W'(prod);

  // Output alignment. Shifting right with >>> floors (toward minus
  // infinity). The final selection keeps the low Y_WORD_LEN bits, so
  // results outside the output range wrap.
  generate
    if (Y_FRAC_LEN <= P_FRAC) begin : g_trunc
      localparam int SHR = P_FRAC - Y_FRAC_LEN;
      logic signed [ACC_W-1:0] shifted;
      assign shifted = acc_sum >>> SHR;
      if (Y_WORD_LEN <= ACC_W) begin : g_narrow
        assign y_aligned = shifted[Y_WORD_LEN-1:0];
      end else begin : g_wide
        assign y_aligned = Y_WORD_LEN'(shifted);
      end
    end else begin : g_pad
      localparam int SHL = Y_FRAC_LEN - P_FRAC;
      logic signed [ACC_W+SHL-1:0] shifted;
      assign shifted = {acc_sum, {SHL{1'b0}}};
      if (Y_WORD_LEN <= ACC_W + SHL) begin : g_narrow
        assign y_aligned = shifted[Y_WORD_LEN-1:0];
      end else begin : g_wide
        assign y_aligned = Y_WORD_LEN'(shifted);
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MAC;
      end
      MAC: begin
        if (tap_cnt == '0) next_state = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath, delay line and coefficient store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      tap_cnt  <= '0;
      acc      <= '0;
      out_data <= '0;
      coef_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        xline[i] <= '0;
        hcoef[i] <= '0;
      end
    end else begin
      coef_err <= coef_we && (state != IDLE);

      // A write in the same edge as an accept lands before the first MAC
      // cycle reads it, so that computation already sees the new value.
      if (coef_we && (state == IDLE) && addr_ok)
        hcoef[coef_addr] <= coef_data;

      case (state)
        IDLE: begin
          if (accept) begin
            xline[wr_ptr] <= in_data;
            acc           <= '0;
            tap_cnt       <= AW'(TAPS - 1);
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (tap_cnt == '0) begin
            out_data <= y_aligned;
            wr_ptr   <= wr_ptr + AW'(1);
          end else begin
            tap_cnt <= tap_cnt - AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with default parameters
// (TAPS=8, all formats Q1.8 in 9 bits).
module tb_fir_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [8:0] coef_data;
  logic       coef_err;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reset and driver tasks
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [8:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 9'(16 * (k + 1)));
  endtask

  task automatic load_const(input logic [8:0] d);
    for (int k = 0; k < 8; k++) write_coef(3'(k), d);
  endtask

  task automatic send(input logic [8:0] d);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input string name, input logic [8:0] exp);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s: out_valid timeout, required data %h", name, exp);
    end else if (out_data !== exp) begin
      n_fail++;
      $display("FAIL %s: out_data=%h required %h", name, out_data, exp);
    end
    @(posedge clk); #1;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
    n_cmp++; if (out_data !== 9'h000) begin n_fail++; $display("FAIL rst_out_data: %h required 000", out_data); end
    n_cmp++; if (coef_err !== 1'b0)  begin n_fail++; $display("FAIL rst_coef_err: %b required 0", coef_err); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: %0d required 0", dbg_state); end
    @(posedge clk); #1 rst = 1'b0;
    // Coefficients come out of reset as zero, so any input yields zero.
    send(9'h080);
    recv("rst_zero_coef", 9'h000);
  endtask

  task automatic test_impulse();
    do_reset();
    load_ramp();
    for (int n = 0; n < 8; n++) exp_q.push_back(9'(8 * (n + 1)));
    for (int n = 0; n < 8; n++) begin
      send((n == 0) ? 9'h080 : 9'h000);
      recv($sformatf("impulse_%0d", n), exp_q.pop_front());
    end
  endtask

  task automatic test_latency();
    do_reset();
    load_ramp();
    send(9'h080);   // now 1 time unit after accept edge t
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== (i == 8)) begin
        n_fail++;
        $display("FAIL latency_out_valid_t+%0d: %b required %b", i, out_valid, (i == 8));
      end
      n_cmp++;
      if (in_ready !== (i == 9)) begin
        n_fail++;
        $display("FAIL latency_in_ready_t+%0d: %b required %b", i, in_ready, (i == 9));
      end
      if (i == 8) begin
        n_cmp++;
        if (out_data !== 9'h008) begin
          n_fail++;
          $display("FAIL latency_data: %h required 008", out_data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    load_ramp();
    out_ready = 1'b0;
    send(9'h080);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    in_valid = 1'b1;
    in_data  = 9'h0FF;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_out_valid_%0d: %b required 1", c, out_valid); end
      n_cmp++; if (out_data !== 9'h008) begin n_fail++; $display("FAIL bp_out_data_%0d: %h required 008", c, out_data); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready_%0d: %b required 0", c, in_ready); end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready: %b required 1", in_ready); end
    // The 0x0FF offered during OUT must not have entered the delay line.
    send(9'h000);
    recv("bp_next", 9'h010);
  endtask

  task automatic test_coef_err();
    do_reset();
    load_ramp();
    send(9'h080);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 9'h0FF;
    @(posedge clk); #1;
    coef_we = 1'b0;
    n_cmp++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL coef_err_pulse: %b required 1", coef_err); end
    @(posedge clk); #1;
    n_cmp++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL coef_err_single: %b required 0", coef_err); end
    recv("coef_err_result", 9'h008);
  endtask

  task automatic test_coef_same_edge();
    do_reset();
    load_ramp();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 9'h040;
    send(9'h080);
    coef_we = 1'b0;
    recv("coef_same_edge", 9'h020);
    // (0x040 + 0x020) * 0.5 with the new h[0] kept
    send(9'h080);
    recv("coef_same_edge_next", 9'h030);
  endtask

  task automatic test_reset_mid_mac();
    bit seen;
    do_reset();
    load_ramp();
    send(9'h080);
    recv("mid_pre", 9'h008);
    send(9'h080);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_in_ready: %b required 1", in_ready); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state: %0d required 0", dbg_state); end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0)     begin n_fail++; $display("FAIL mid_no_output: seen=%b required 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: %b required 1", in_ready); end
    load_ramp();
    send(9'h080);
    recv("mid_zero_history", 9'h008);
  endtask

  task automatic test_wrap();
    int v;
    logic [31:0] w;
    do_reset();
    load_const(9'h0FF);
    for (int n = 0; n < 8; n++) begin
      v = ((n + 1) * 65025) >>> 8;
      w = v;
      exp_q.push_back(w[8:0]);
    end
    for (int n = 0; n < 8; n++) begin
      send(9'h0FF);
      recv($sformatf("wrap_%0d", n), exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_backpressure();
    test_coef_err();
    test_coef_same_edge();
    test_reset_mid_mac();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
